// File: rtl/prio_select_n_if.sv
// Channel-side and output-side handshake bundle for prio_select_n.
// The arbiter uses the slave view; whoever drives requests and consumes results uses the master view.
interface prio_select_n_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int IDW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [IDW-1:0]     out_id;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/prio_select_n.sv
// N-channel arbiter, fixed-priority or round-robin, into a single registered output word.
// Latency: 1 cycle from acceptance to out_valid. Backpressure: an unaccepted output word stalls and blocks every channel.
module prio_select_n #(
    parameter int WIDTH        = 8,
    parameter int N            = 4,
    parameter int ZERO_IS_IDLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    prio_select_n_if.slave  bus
);
    localparam int IDW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic             load;
    logic [IDW-1:0]   fix_win;
    logic [IDW-1:0]   hi_win;
    logic             hi_found;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] win_data;
    logic [N-1:0]     in_ready_c;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [IDW-1:0]   out_id_d,    out_id_q;
    logic [IDW-1:0]   ptr_d,       ptr_q;

    always_comb begin
        req      = '0;
        fix_win  = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = bus.in_valid[i] &&
                     ((ZERO_IS_IDLE == 0) || (bus.in_data[i*WIDTH +: WIDTH] != '0));
        end
        // Round-robin: lowest requester at or above ptr, else wrap to the lowest requester overall.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                fix_win = IDW'(i);
                if (IDW'(i) >= ptr_q) begin
                    hi_win   = IDW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_id = (mode && hi_found) ? hi_win : fix_win;

        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_id == IDW'(i)) begin
                win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end

        // Gating on rst_n keeps in_ready quiet while reset is held, independent of the clock.
        load = rst_n && (|req) && (!out_valid_q || bus.out_ready);

        in_ready_c = '0;
        if (load) begin
            in_ready_c[win_id] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_id_d    = win_id;
            if (mode) begin
                ptr_d = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
endmodule
